// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sequencer.
// Provides the FSM state encoding and the count-mode constants.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_ctrl_if.sv
// Configuration handshake bundle for the counter sequencer.
// master: cfg_valid/cfg_term/cfg_periodic out, cfg_ready in; slave mirrors.
interface counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_term;
    logic             cfg_periodic;

    modport master (
        output cfg_valid,
        output cfg_term,
        output cfg_periodic,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_term,
        input  cfg_periodic,
        output cfg_ready
    );
endinterface

// File: rtl/counter_ctrl_prescaler.sv
// Count-step strobe generator: counts 0..PRESCALE-1 while en, strobes on last.
// Ports: clk, resetn (async low), en, clr (sync clear), strobe.
module counter_ctrl_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic strobe
);
    // Keep at least one bit so PRESCALE = 1 still elaborates.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    assign strobe = en && (pcnt == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
        end
    end
endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for the shared up-counter: accepts term/mode, counts, emits tick.
// Ports: clk, resetn, cfg (slave handshake), hold, stop, count, tick, busy,
// done, ticks. Macro COUNTER_CTRL_PRESCALE_EN inserts a count-step prescaler.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             resetn,
    counter_ctrl_if.slave    cfg,
    input  logic             hold,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ticks
);
    state_t           state;
    logic [WIDTH-1:0] term_q;
    logic             mode_q;
    logic             xfer;
    logic             run_en;
    logic             strobe;
    logic             step;

    assign run_en = (state == RUN) && !hold;

`ifdef COUNTER_CTRL_PRESCALE_EN
    counter_ctrl_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .en     (run_en),
        .clr    (stop || xfer),
        .strobe (strobe)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign strobe = 1'b1;
`endif

    // Ready is gated by resetn so nothing is accepted while held in reset.
    assign cfg.cfg_ready = resetn && !stop && (state != RUN);
    assign xfer = cfg.cfg_valid && cfg.cfg_ready;
    assign step = run_en && strobe;
    assign tick = step && (count == term_q);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            count  <= '0;
            ticks  <= '0;
            term_q <= '0;
            mode_q <= MODE_ONESHOT;
        end else if (stop) begin
            // A tick driven this cycle is dropped: stop wins.
            state <= IDLE;
            count <= '0;
        end else if (xfer) begin
            state  <= RUN;
            term_q <= cfg.cfg_term;
            mode_q <= cfg.cfg_periodic;
            count  <= '0;
            ticks  <= '0;
        end else if (step) begin
            if (tick) begin
                count <= '0;
                if (ticks != '1) begin
                    ticks <= ticks + 1'b1;
                end
                if (mode_q == MODE_ONESHOT) begin
                    state <= DONE;
                end
            end else begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_counter_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         hold;
    logic         stop;
    logic [W-1:0] count;
    logic         tick;
    logic         busy;
    logic         done;
    logic [W-1:0] ticks;

    int checks = 0;
    int failures = 0;

    counter_ctrl_if #(.WIDTH(W)) cfg_if ();

    counter_ctrl #(
        .WIDTH    (W),
        .PRESCALE (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .cfg    (cfg_if.slave),
        .hold   (hold),
        .stop   (stop),
        .count  (count),
        .tick   (tick),
        .busy   (busy),
        .done   (done),
        .ticks  (ticks)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer a config for exactly one edge, then withdraw it.
    task automatic load(input logic [W-1:0] t, input logic p);
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_term     = t;
        cfg_if.cfg_periodic = p;
        chk("load_ready", {31'd0, cfg_if.cfg_ready}, 1);
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int cyc;
        resetn = 1'b0;
        hold = 1'b0;
        stop = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_term = '0;
        cfg_if.cfg_periodic = 1'b0;
        #1;
        chk("rst_count", {28'd0, count}, 0);
        chk("rst_ticks", {28'd0, ticks}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_tick", {31'd0, tick}, 0);
        chk("rst_ready", {31'd0, cfg_if.cfg_ready}, 0);
        step();
        resetn = 1'b1;
        #1;
        chk("idle_ready", {31'd0, cfg_if.cfg_ready}, 1);

`ifdef COUNTER_CTRL_PRESCALE_EN
        // term = 1, PRESCALE = 4: ticks must be 8 cycles apart.
        load(4'd1, 1'b1);
        n = 0;
        while (!tick && n < 50) begin step(); n++; end
        chk("ps_first_seen", {31'd0, tick}, 1);
        step();
        cyc = 1;
        while (!tick && cyc < 50) begin step(); cyc++; end
        chk("ps_period", cyc, 8);
`else
        // One-shot, term = 3.
        load(4'd3, 1'b0);
        chk("os_busy", {31'd0, busy}, 1);
        chk("os_ready_run", {31'd0, cfg_if.cfg_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            chk("os_count", {28'd0, count}, i);
            chk("os_tick", {31'd0, tick}, (i == 3) ? 1 : 0);
            step();
        end
        chk("os_done", {31'd0, done}, 1);
        chk("os_busy_end", {31'd0, busy}, 0);
        chk("os_count_end", {28'd0, count}, 0);
        chk("os_ticks", {28'd0, ticks}, 1);
        chk("os_tick_end", {31'd0, tick}, 0);
        step();
        chk("os_done_hold", {31'd0, done}, 1);

        // Periodic, term = 2, 9 cycles -> 3 ticks.
        load(4'd2, 1'b1);
        chk("per_ticks_clr", {28'd0, ticks}, 0);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            chk("per_tick", {31'd0, tick}, (i % 3 == 2) ? 1 : 0);
            if (tick) n++;
            step();
        end
        chk("per_pulses", n, 3);
        chk("per_ticks", {28'd0, ticks}, 3);
        chk("per_busy", {31'd0, busy}, 1);

        // Stop out of RUN keeps ticks.
        stop = 1'b1;
        #1;
        chk("stop_ready", {31'd0, cfg_if.cfg_ready}, 0);
        step();
        stop = 1'b0;
        #1;
        chk("stop_busy", {31'd0, busy}, 0);
        chk("stop_count", {28'd0, count}, 0);
        chk("stop_ticks", {28'd0, ticks}, 3);
        chk("stop_ready_idle", {31'd0, cfg_if.cfg_ready}, 1);

        // term = 5, hold 4 cycles at count 2 -> first tick in cycle 10.
        load(4'd5, 1'b0);
        step();
        step();
        chk("hold_pre", {28'd0, count}, 2);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_count", {28'd0, count}, 2);
            chk("hold_tick", {31'd0, tick}, 0);
            step();
        end
        hold = 1'b0;
        #1;
        chk("hold_release", {28'd0, count}, 2);
        cyc = 7;
        while (!tick && cyc < 30) begin step(); cyc++; end
        chk("hold_first_tick_cycle", cyc, 10);
        step();
        chk("hold_done", {31'd0, done}, 1);
        chk("hold_ticks", {28'd0, ticks}, 1);

        // Stop coincident with terminal count.
        load(4'd1, 1'b0);
        step();
        stop = 1'b1;
        #1;
        chk("stoptick_tick", {31'd0, tick}, 1);
        step();
        stop = 1'b0;
        #1;
        chk("stoptick_busy", {31'd0, busy}, 0);
        chk("stoptick_done", {31'd0, done}, 0);
        chk("stoptick_count", {28'd0, count}, 0);
        chk("stoptick_ticks", {28'd0, ticks}, 0);

        // Async reset mid-run at count 4.
        load(4'd6, 1'b1);
        for (int i = 0; i < 4; i++) step();
        chk("mid_count", {28'd0, count}, 4);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_count", {28'd0, count}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_tick", {31'd0, tick}, 0);
        chk("arst_ready", {31'd0, cfg_if.cfg_ready}, 0);
        resetn = 1'b1;
        #1;
        chk("arst_ready_rel", {31'd0, cfg_if.cfg_ready}, 1);
        step();

        // term = 15 periodic: 20 ticks, counter saturates at 15.
        load(4'd15, 1'b1);
        n = 0;
        cyc = 0;
        while (n < 20 && cyc < 400) begin
            if (tick) n++;
            step();
            cyc++;
        end
        chk("sat_pulses", n, 20);
        chk("sat_cycles", cyc, 320);
        chk("sat_ticks", {28'd0, ticks}, 15);
        chk("sat_busy", {31'd0, busy}, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
